// File: rtl/pixel_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pixel_fetch_pkg
// Shared definitions for the VRAM pixel fetcher: FSM state encoding, VRAM
// geometry and the 15-bit PSX colour to 36-bit {R12,G12,B12} expansion.
// ---------------------------------------------------------------------------
package pixel_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;

   localparam int VRAM_W = 1024;            // halfwords per VRAM row
   localparam int VRAM_H = 512;             // VRAM rows
   localparam int COL_W  = $clog2(VRAM_W);  // 10-bit column address
   localparam int ROW_W  = $clog2(VRAM_H);  // 9-bit row address
   localparam int PIX_W  = 36;              // expanded pixel width

   // Bit replication keeps full-scale white at 0xFFF and black at 0.
   function automatic logic [11:0] widen(input logic [4:0] c);
      return {c, c, c[4:3]};
   endfunction

   // px[4:0] R, px[9:5] G, px[14:10] B; the mask bit carries no colour.
   function automatic logic [PIX_W-1:0] expand(input logic [14:0] px);
      return {widen(px[4:0]), widen(px[9:5]), widen(px[14:10])};
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
// Synchronous first-word-fall-through FIFO for expanded pixels.
//   clk, rst      clock, asynchronous active-high reset
//   wr_en/wr_data push one word
//   rd_en         pop the head word (ignored while empty)
//   rd_data       head word, 0 while empty
//   count         number of stored words (0..DEPTH)
//   empty         count == 0
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module pixel_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 36
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign do_rd = rd_en && !empty;
   assign do_wr = wr_en && (!full || do_rd);

   assign rd_data = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and count alone define
   // which entries are valid, so the RAM can map onto plain memory cells.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pixel_fetch.sv
// ---------------------------------------------------------------------------
// pixel_fetch
// Fetches one H_ACTIVE x V_ACTIVE window of PSX 15-bit pixels from VRAM,
// expands them to 36-bit RGB and hands them to a display timing block
// through a first-word-fall-through FIFO.
//   clk, rst          clock, asynchronous active-high reset
//   en                start a frame (sampled in IDLE only)
//   x_start, y_start  VRAM origin of the window, latched at frame start
//   rd_req, rd_addr   read request, address {row, col}
//   rd_gnt            request accepted this cycle
//   rd_valid, rd_data in-order read return
//   pix_req           downstream consumes one pixel this cycle
//   pix_data          FIFO head {R12,G12,B12}, 0 while empty
//   underflow         sticky: pix_req seen with empty FIFO
//   frame_done        one-cycle pulse once the frame is fully consumed
// ---------------------------------------------------------------------------
module pixel_fetch
   import pixel_fetch_pkg::*;
#(
   parameter int H_ACTIVE   = 720,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [COL_W-1:0]     x_start,
   input  logic [ROW_W-1:0]     y_start,
   output logic                 rd_req,
   output logic [ROW_W+COL_W-1:0] rd_addr,
   input  logic                 rd_gnt,
   input  logic                 rd_valid,
   input  logic [15:0]          rd_data,
   input  logic                 pix_req,
   output logic [PIX_W-1:0]     pix_data,
   output logic                 underflow,
   output logic                 frame_done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(V_ACTIVE - 1);
   localparam logic [CNT_W:0]   SLOT_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

   state_t           state;
   logic [COL_W-1:0] x_lat;
   logic [ROW_W-1:0] y_lat;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic [CNT_W:0]   in_flight;
   logic [COL_W-1:0] col_addr;
   logic [ROW_W-1:0] row_addr;
   logic             grant;
   logic             accept;
   logic             unused_mask;

   assign unused_mask = rd_data[15];

   // Every request reserves a FIFO slot, so the FIFO can never overflow.
   assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
   assign rd_req    = (state == FETCH) && (in_flight < SLOT_LIMIT);
   assign grant     = rd_req && rd_gnt;

   // Returns with nothing outstanding are stale (e.g. after a reset).
   assign accept    = rd_valid && (outstanding != '0);

   // Natural truncation wraps both coordinates inside VRAM.
   assign col_addr  = x_lat + col;
   assign row_addr  = y_lat + row;
   assign rd_addr   = {row_addr, col_addr};

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_data (expand(rd_data[14:0])),
      .rd_en   (pix_req),
      .rd_data (pix_data),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({grant, accept})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         x_lat      <= '0;
         y_lat      <= '0;
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (pix_req && fifo_empty) underflow <= 1'b1;

         case (state)
            IDLE: begin
               x_lat <= x_start;
               y_lat <= y_start;
               col   <= '0;
               row   <= '0;
               // Frame start wins over a same-cycle underflow event.
               if (en) begin
                  state     <= FETCH;
                  underflow <= 1'b0;
               end
            end

            FETCH: begin
               if (grant) begin
                  if (col == COL_LAST) begin
                     col <= '0;
                     if (row == ROW_LAST) begin
                        row   <= '0;
                        state <= DRAIN;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end

            DRAIN: begin
               if (outstanding == '0 && fifo_empty) begin
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
